// File: rtl/acq_sched_pkg.sv
// acq_sched_pkg: shared types and constants for the acquisition scheduler
package acq_sched_pkg;
    typedef enum logic [1:0] {IDLE, WAIT_PERIOD, ACQUIRE, DRAIN} state_t;
    typedef logic bank_t;
    localparam int TIMEOUT_MARGIN = 16;
    localparam int BANK_COUNT = 2;
    localparam int TO_W = 12;
endpackage

// File: rtl/acq_period_timer.sv
// acq_period_timer: loadable down-counter, ticks while enabled at zero, clears when idle
module acq_period_timer #(
    parameter int W = 24
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         en_i,
    output logic         tick_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign tick_o = en_i && cnt_q == '0;
    always_comb cnt_d = load_i ? load_val_i : !en_i ? '0 : cnt_q - 1'b1;
    always_ff @(posedge clk) cnt_q <= !rstn ? '0 : cnt_d;
endmodule

// File: rtl/acquisition_scheduler.sv
// acquisition_scheduler: periodic window trigger, ping-pong bank tracking and Goertzel dispatch
module acquisition_scheduler
    import acq_sched_pkg::*;
#(
    parameter int P_PERIOD_W = 24,
    parameter int P_CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  i_enable,
    input  logic [9:0]            i10_window_length,
    input  logic [P_PERIOD_W-1:0] i_period,
    input  logic                  i_acq_done,
    input  logic                  i_proc_done,
    output logic                  o_acquire_window,
    output logic                  o_wr_bank,
    output logic                  o_proc_start,
    output logic                  o_proc_bank,
    output logic                  o_busy,
    output logic                  o_irq,
    output logic                  o_overrun,
    output logic                  o_timeout,
    output logic                  o_cfg_error,
    output logic [P_CNT_W-1:0]    o_window_count,
    output logic [P_CNT_W-1:0]    o_overrun_count
);
    state_t state_q;
    logic en_q, acq_win_q, start_q, eng_busy_q, overrun_q, timeout_q, cfg_err_q;
    bank_t wr_bank_q, wr_bank_d, proc_bank_q, proc_bank_d;
    logic [BANK_COUNT-1:0] full_q, full_d;
    logic [P_CNT_W-1:0] win_cnt_q, ovr_cnt_q;
    logic per_tick, to_tick, cfg_ok, per_load, trig, skip, acq_ok, start_d;

    acq_period_timer #(.W(P_PERIOD_W)) u_period (
        .clk(clk), .rstn(rstn), .load_i(per_load), .load_val_i(i_period - 1'b1),
        .en_i(state_q == WAIT_PERIOD || state_q == ACQUIRE), .tick_o(per_tick)
    );

    acq_period_timer #(.W(TO_W)) u_timeout (
        .clk(clk), .rstn(rstn), .load_i(trig),
        .load_val_i(TO_W'({i10_window_length, 1'b0}) + TO_W'(TIMEOUT_MARGIN - 1)),
        .en_i(state_q == ACQUIRE), .tick_o(to_tick)
    );

    always_comb begin
        cfg_ok = |i10_window_length && |i_period;
        per_load = (state_q == IDLE && i_enable && cfg_ok) || per_tick;
        trig = state_q == WAIT_PERIOD && i_enable && per_tick && !full_q[wr_bank_q];
        skip = per_tick && (state_q == ACQUIRE || (state_q == WAIT_PERIOD && i_enable && full_q[wr_bank_q]));
        acq_ok = state_q == ACQUIRE && i_acq_done;
        wr_bank_d = wr_bank_q ^ acq_ok;
        full_d = full_q;
        if (acq_ok) full_d[wr_bank_q] = 1'b1;
        if (eng_busy_q && i_proc_done) full_d[proc_bank_q] = 1'b0;
        start_d = !eng_busy_q && |full_d;
        // with both banks full the write pointer has wrapped onto the older one
        proc_bank_d = &full_d ? wr_bank_d : full_d[1];
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            {en_q, acq_win_q, start_q, eng_busy_q, overrun_q, timeout_q, cfg_err_q} <= '0;
            {wr_bank_q, proc_bank_q} <= '0;
            full_q <= '0;
            win_cnt_q <= '0;
            ovr_cnt_q <= '0;
        end else begin
            en_q <= i_enable;
            acq_win_q <= trig;
            full_q <= full_d;
            start_q <= start_d;
            eng_busy_q <= start_d || (eng_busy_q && !i_proc_done);
            if (start_d) proc_bank_q <= proc_bank_d;
            if (i_enable && !en_q) {overrun_q, timeout_q, cfg_err_q} <= '0;
            if (skip) begin
                overrun_q <= 1'b1;
                ovr_cnt_q <= ovr_cnt_q + P_CNT_W'(!(&ovr_cnt_q));
            end
            case (state_q)
                IDLE: if (i_enable) begin
                    if (cfg_ok) state_q <= WAIT_PERIOD;
                    else cfg_err_q <= 1'b1;
                end
                WAIT_PERIOD: state_q <= !i_enable ? DRAIN : trig ? ACQUIRE : WAIT_PERIOD;
                ACQUIRE: if (i_acq_done || to_tick) begin
                    state_q <= i_enable ? WAIT_PERIOD : DRAIN;
                    if (i_acq_done) begin
                        win_cnt_q <= win_cnt_q + 1'b1;
                        wr_bank_q <= wr_bank_d;
                    end else timeout_q <= 1'b1;
                end
                DRAIN: if (!eng_busy_q && ~|full_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign o_acquire_window = acq_win_q;
    assign o_wr_bank = wr_bank_q;
    assign o_proc_start = start_q;
    assign o_irq = start_q;
    assign o_proc_bank = proc_bank_q;
    assign o_busy = state_q != IDLE;
    assign o_overrun = overrun_q;
    assign o_timeout = timeout_q;
    assign o_cfg_error = cfg_err_q;
    assign o_window_count = win_cnt_q;
    assign o_overrun_count = ovr_cnt_q;
endmodule

// File: tb/tb_acquisition_scheduler.sv
// tb_acquisition_scheduler: directed checks of window timing, dispatch, overrun, timeout, cfg error, drain and reset
module tb_acquisition_scheduler;
    logic        clk = 1'b0, rstn = 1'b0, i_enable = 1'b0, i_acq_done = 1'b0, i_proc_done = 1'b0;
    logic [9:0]  i10_window_length = 10'd64;
    logic [23:0] i_period = 24'd100;
    logic        o_acquire_window, o_wr_bank, o_proc_start, o_proc_bank, o_busy, o_irq;
    logic        o_overrun, o_timeout, o_cfg_error;
    logic [15:0] o_window_count, o_overrun_count;
    int n_tests = 0, n_fail = 0, t = 0, t0 = 0, ta = 0;
    bit hit;

    acquisition_scheduler #(.P_PERIOD_W(24), .P_CNT_W(16)) dut (
        .clk(clk), .rstn(rstn), .i_enable(i_enable), .i10_window_length(i10_window_length),
        .i_period(i_period), .i_acq_done(i_acq_done), .i_proc_done(i_proc_done),
        .o_acquire_window(o_acquire_window), .o_wr_bank(o_wr_bank), .o_proc_start(o_proc_start),
        .o_proc_bank(o_proc_bank), .o_busy(o_busy), .o_irq(o_irq), .o_overrun(o_overrun),
        .o_timeout(o_timeout), .o_cfg_error(o_cfg_error), .o_window_count(o_window_count),
        .o_overrun_count(o_overrun_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic wait_acq(input int max, output bit found);
        found = 1'b0;
        for (int i = 0; i < max && !found; i++) begin
            step();
            found = o_acquire_window;
        end
    endtask

    task automatic pulse_acq();
        i_acq_done = 1'b1;
        step();
        i_acq_done = 1'b0;
    endtask

    task automatic pulse_proc();
        i_proc_done = 1'b1;
        step();
        i_proc_done = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        i_enable = 1'b0;
        i_period = 24'd100;
        i10_window_length = 10'd64;
        step();
        step();
        rstn = 1'b1;
    endtask

    initial begin
        do_reset();
        chk("rst_flags", {o_acquire_window, o_wr_bank, o_proc_start, o_proc_bank, o_busy, o_irq,
                          o_overrun, o_timeout, o_cfg_error}, 0);
        chk("rst_wcnt", o_window_count, 0);
        chk("rst_ocnt", o_overrun_count, 0);

        // normal ping-pong flow
        i_enable = 1'b1;
        t0 = t;
        for (int k = 0; k < 3; k++) begin
            wait_acq(200, hit);
            chk("norm_acq_seen", hit, 1);
            if (k == 0) chk("norm_first_lat", t - t0, 101);
            else chk("norm_period", t - ta, 100);
            ta = t;
            chk("norm_wr_bank", o_wr_bank, k % 2);
            repeat (10) step();
            pulse_acq();
            chk("norm_start", o_proc_start, 1);
            chk("norm_irq", o_irq, 1);
            chk("norm_proc_bank", o_proc_bank, k % 2);
            repeat (19) step();
            pulse_proc();
        end
        chk("norm_flags", {o_overrun, o_timeout, o_cfg_error}, 0);
        chk("norm_wcnt", o_window_count, 3);

        // engine never releases: third tick skipped
        do_reset();
        i_enable = 1'b1;
        wait_acq(200, hit);
        chk("ovr_acq0", hit, 1);
        repeat (10) step();
        pulse_acq();
        chk("ovr_start0", o_proc_start, 1);
        wait_acq(200, hit);
        chk("ovr_acq1", hit, 1);
        ta = t;
        chk("ovr_wr_bank1", o_wr_bank, 1);
        repeat (10) step();
        pulse_acq();
        chk("ovr_no_start", o_proc_start, 0);
        chk("ovr_wr_bank0", o_wr_bank, 0);
        while (t < ta + 99) step();
        chk("ovr_before", o_overrun, 0);
        step();
        chk("ovr_flag", o_overrun, 1);
        chk("ovr_cnt1", o_overrun_count, 1);
        chk("ovr_no_acq", o_acquire_window, 0);
        repeat (100) step();
        chk("ovr_cnt2", o_overrun_count, 2);
        chk("ovr_wcnt", o_window_count, 2);

        // acquisition never completes
        do_reset();
        i_enable = 1'b1;
        wait_acq(200, hit);
        chk("to_acq", hit, 1);
        t0 = t;
        while (t < t0 + 143) step();
        chk("to_before", o_timeout, 0);
        chk("to_tick_overrun", o_overrun_count, 1);
        step();
        chk("to_flag", o_timeout, 1);
        chk("to_wr_bank", o_wr_bank, 0);
        chk("to_wcnt", o_window_count, 0);
        wait_acq(200, hit);
        chk("to_retry_seen", hit, 1);
        chk("to_retry_time", t - t0, 200);
        chk("to_retry_bank", o_wr_bank, 0);

        // zero period is rejected, then cleared on a fresh enable edge
        do_reset();
        i_period = 24'd0;
        i_enable = 1'b1;
        repeat (3) step();
        chk("cfg_err", o_cfg_error, 1);
        chk("cfg_busy", o_busy, 0);
        wait_acq(150, hit);
        chk("cfg_no_acq", hit, 0);
        i_enable = 1'b0;
        step();
        i_period = 24'd100;
        i_enable = 1'b1;
        step();
        chk("cfg_cleared", o_cfg_error, 0);
        chk("cfg_busy_ok", o_busy, 1);

        // disable mid-window: complete, process, drain
        do_reset();
        i_enable = 1'b1;
        wait_acq(200, hit);
        chk("drn_acq", hit, 1);
        repeat (5) step();
        i_enable = 1'b0;
        repeat (5) step();
        chk("drn_busy_acq", o_busy, 1);
        pulse_acq();
        chk("drn_start", o_proc_start, 1);
        chk("drn_bank", o_proc_bank, 0);
        chk("drn_wcnt", o_window_count, 1);
        repeat (19) step();
        chk("drn_busy_wait", o_busy, 1);
        pulse_proc();
        chk("drn_busy_last", o_busy, 1);
        step();
        chk("drn_idle", o_busy, 0);

        // reset asserted during an acquisition
        do_reset();
        i_enable = 1'b1;
        wait_acq(200, hit);
        repeat (10) step();
        pulse_acq();
        wait_acq(200, hit);
        chk("mid_acq2", hit, 1);
        repeat (3) step();
        rstn = 1'b0;
        step();
        chk("mid_flags", {o_acquire_window, o_wr_bank, o_proc_start, o_proc_bank, o_busy, o_irq,
                          o_overrun, o_timeout, o_cfg_error}, 0);
        chk("mid_wcnt", o_window_count, 0);
        chk("mid_ocnt", o_overrun_count, 0);
        rstn = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end
endmodule
